// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: RV32I funct3
// codes for loads and stores, FSM state encoding and the legality check.
package dmem_access_ctrl_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_RESP = 2'd2,
        S_WB   = 2'd3
    } state_t;

    // Unsigned variants exist only for loads; halves and words must be naturally aligned.
    function automatic logic is_legal(input logic i_write, input logic [2:0] i_f3,
                                      input logic [1:0] i_addr_lo);
        case (i_f3)
            F3_LB:   is_legal = 1'b1;
            F3_LH:   is_legal = ~i_addr_lo[0];
            F3_LW:   is_legal = (i_addr_lo == 2'b00);
            F3_LBU:  is_legal = ~i_write;
            F3_LHU:  is_legal = ~i_write & ~i_addr_lo[0];
            default: is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_lane_align.sv
// Byte-lane steering: store byte enables and data replication, and load
// shift plus sign/zero extension. Purely combinational.
module dmem_access_ctrl_lane_align
    import dmem_access_ctrl_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shifted;

    always_comb begin
        o_byte_en = 4'b1111;
        o_wdata   = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                o_byte_en = 4'b0001 << i_addr_lo;
                o_wdata   = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_byte_en = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata   = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

    always_comb begin
        o_rdata = w_shifted;
        case (i_funct3)
            F3_LB:   o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_LH:   o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_LBU:  o_rdata = {24'd0, w_shifted[7:0]};
            F3_LHU:  o_rdata = {16'd0, w_shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequences EX-stage loads/stores onto a valid/ready data-memory bus,
// stalling the pipeline while an access is in flight.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reqValid,
    input  logic              reqWrite,
    input  logic [2:0]        reqFunct3,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [31:0]       reqWdata,
    input  logic [4:0]        reqRd,
    input  logic              flush,
    output logic              stall,
    output logic              busValid,
    output logic              busWrite,
    output logic [ADDR_W-1:0] busAddr,
    output logic [31:0]       busWdata,
    output logic [3:0]        busByteEn,
    input  logic              busReady,
    input  logic              busRspValid,
    input  logic [31:0]       busRdata,
    output logic              wbValid,
    output logic [4:0]        wbRd,
    output logic [31:0]       wbData,
    output logic              accessErr,
    output logic              timeoutErr
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            r_state;
    state_t            w_next;
    logic              r_write;
    logic [2:0]        r_f3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [4:0]        r_rd;
    logic [31:0]       r_rdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_squash;
    logic              r_acc_err;
    logic              r_to_err;

    logic              w_legal;
    logic              w_accept;
    logic              w_expire;
    logic              w_timeout;
    logic              w_in_addr;
    logic [3:0]        w_byte_en;
    logic [31:0]       w_wdata_rep;
    logic [31:0]       w_load_ext;

    assign w_legal   = is_legal(reqWrite, reqFunct3, reqAddr[1:0]);
    assign w_accept  = (r_state == S_IDLE) && reqValid && !flush && w_legal;
    assign w_expire  = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_in_addr = (r_state == S_ADDR);

    dmem_access_ctrl_lane_align u_align (
        .i_funct3  (r_f3),
        .i_addr_lo (r_addr[1:0]),
        .i_wdata   (r_wdata),
        .i_rdata   (busRdata),
        .o_byte_en (w_byte_en),
        .o_wdata   (w_wdata_rep),
        .o_rdata   (w_load_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A handshake or response in the final budget cycle still wins over the timeout.
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_ADDR;
            S_ADDR: begin
                if (busReady) begin
                    w_next = r_write ? S_IDLE : S_RESP;
                end else if (flush) begin
                    w_next = S_IDLE;
                end else if (w_expire) begin
                    w_next    = S_IDLE;
                    w_timeout = 1'b1;
                end
            end
            S_RESP: begin
                if (busRspValid) begin
                    w_next = S_WB;
                end else if (w_expire) begin
                    w_next    = S_IDLE;
                    w_timeout = 1'b1;
                end
            end
            S_WB:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write   <= 1'b0;
            r_f3      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rd      <= '0;
            r_rdata   <= '0;
            r_cnt     <= '0;
            r_squash  <= 1'b0;
            r_acc_err <= 1'b0;
            r_to_err  <= 1'b0;
        end else begin
            r_acc_err <= (r_state == S_IDLE) && reqValid && !flush && !w_legal;
            r_to_err  <= w_timeout;
            if (w_accept) begin
                r_write  <= reqWrite;
                r_f3     <= reqFunct3;
                r_addr   <= reqAddr;
                r_wdata  <= reqWdata;
                r_rd     <= reqRd;
                r_cnt    <= '0;
                r_squash <= 1'b0;
            end else if (r_state == S_ADDR || r_state == S_RESP) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Once the bus has committed to the access, a flush only hides the result.
            if (flush && ((w_in_addr && busReady) || r_state == S_RESP)) begin
                r_squash <= 1'b1;
            end
            if (r_state == S_RESP && busRspValid) begin
                r_rdata <= w_load_ext;
            end
        end
    end

    assign stall      = w_accept || w_in_addr || (r_state == S_RESP);
    assign busValid   = w_in_addr;
    assign busWrite   = w_in_addr && r_write;
    assign busAddr    = w_in_addr ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
    assign busWdata   = w_in_addr ? w_wdata_rep : '0;
    assign busByteEn  = w_in_addr ? w_byte_en : '0;
    assign wbValid    = (r_state == S_WB) && (r_rd != 5'd0) && !r_squash;
    assign wbRd       = wbValid ? r_rd : '0;
    assign wbData     = wbValid ? r_rdata : '0;
    assign accessErr  = r_acc_err;
    assign timeoutErr = r_to_err;

endmodule
